// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y coordinate counters,
// registered sync/blank decode and frame strobes for the drawing logic.
module vga_timing_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] xc_o,
    output logic [CNT_W-1:0] yc_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             video_on_o,
    output logic             pixel_tick_o,
    output logic             vblank_start_o,
    output logic             frame_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] xc_q, xc_d, yc_q, yc_d;
    logic             tick_q, tick_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             vblank_q, vblank_d, frame_end_q, frame_end_d;

    always_comb begin
        div_d  = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_q == DIV_MAX);

        xc_d = xc_q;
        yc_d = yc_q;
        if (tick_q) begin
            if (xc_q == H_MAX) begin
                xc_d = '0;
                yc_d = (yc_q == V_MAX) ? '0 : yc_q + CNT_W'(1);
            end else begin
                xc_d = xc_q + CNT_W'(1);
            end
        end

        // Decode from the next coordinates so outputs line up with xc/yc.
        hsync_d    = ((xc_d >= HS_START) && (xc_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = ((yc_d >= VS_START) && (yc_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        video_on_d = (xc_d < H_ACT) && (yc_d < V_ACT);

        // Strobes are high during the tick clk of the pixel they mark.
        vblank_d    = tick_d && (xc_d == H_LAST) && (yc_d == V_LAST);
        frame_end_d = tick_d && (xc_d == H_MAX) && (yc_d == V_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            tick_q      <= 1'b0;
            xc_q        <= '0;
            yc_q        <= '0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            video_on_q  <= 1'b0;
            vblank_q    <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            tick_q      <= tick_d;
            xc_q        <= xc_d;
            yc_q        <= yc_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            vblank_q    <= vblank_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign xc_o           = xc_q;
    assign yc_o           = yc_q;
    assign hsync_o        = hsync_q;
    assign vsync_o        = vsync_q;
    assign video_on_o     = video_on_q;
    assign pixel_tick_o   = tick_q;
    assign vblank_start_o = vblank_q;
    assign frame_end_o    = frame_end_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA 640x480@60 Hz raster timing from the 100 MHz system clock. Outputs the pixel coordinates, sync pulses and blanking/frame strobes. The downstream drawing logic consumes these: the square/sprite renderers and the colour register. Its frame strobes are the sole update trigger for object motion, so that motion happens once per frame during blanking.

Parameters:
CLK_DIV, 4, system clocks per pixel (25 MHz pixel rate); legal values are 2 or greater.
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active sync level (0 = active-low)
CNT_W, 10, coordinate counter width; must be able to hold H_TOTAL-1 and V_TOTAL-1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
xc  out  CNT_W  current pixel column, 0..H_TOTAL-1
yc  out  CNT_W  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
video_on  out  1  high while xc<H_ACTIVE and yc<V_ACTIVE
pixel_tick  out  1  one-clk strobe per pixel period
vblank_start  out  1  one-clk strobe: last visible pixel of the frame is ending
frame_end  out  1  one-clk strobe: last pixel of the frame is ending

Behaviour:
- Reset, clk and reset are fixed: reset is asynchronous and active-high; the clock is clk.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and high for exactly one clk when the divider equals CLK_DIV-1.
  - The period is CLK_DIV clks.
- Coordinate counters, updated only on the clk edge where pixel_tick is high:
  - If xc==H_TOTAL-1: xc<=0. Then yc<=0 if yc==V_TOTAL-1, otherwise yc<=yc+1.
  - Otherwise xc<=xc+1 and yc holds.
  - xc and yc never take values at or above their totals.
- Decode:
  - hsync, vsync and video_on are registered.
  - They are computed from the next-state xc/yc, so they change on the same clk edge as xc/yc. There is no skew to the coordinates.
- hsync is at the active level iff H_ACTIVE+H_FP <= xc <= H_ACTIVE+H_FP+H_SYNC-1, i.e. 656..751.
- vsync is at the active level iff V_ACTIVE+V_FP <= yc <= V_ACTIVE+V_FP+V_SYNC-1, i.e. 490..491.
- Strobes: both are registered and both are coincident with pixel_tick (same clk), each lasting one clk.
  - vblank_start fires when pixel_tick is high and xc==H_ACTIVE-1 and yc==V_ACTIVE-1.
  - frame_end fires when pixel_tick is high and xc==H_TOTAL-1 and yc==V_TOTAL-1.
  - Each fires exactly once per frame and never in the same clk as the other.
- Reset values:
  - Divider, xc and yc are 0.
  - pixel_tick, vblank_start and frame_end are 0.
  - video_on is 0.
  - hsync and vsync are at the inactive level (~SYNC_POL).
- First clk edge after reset release: video_on goes to 1 and the syncs stay inactive, because the decode of (0,0) is active video.
- The first pixel_tick occurs CLK_DIV clks after reset release.
- Reset asserted mid-frame: all state clears immediately (asynchronously), with no partial strobe. Counting restarts at (0,0) on release.
- Rates: the frame period is H_TOTAL*V_TOTAL*CLK_DIV clks, which is 1,680,000 with the defaults.

Test Plan:
- Reset: hold reset 5 clks -> xc=0, yc=0, hsync=1, vsync=1, video_on=0, all strobes 0. Release -> video_on=1 after one clk; first pixel_tick 4 clks after release; thereafter exactly every 4 clks.
- Line timing:
  - hsync falls on the edge where xc becomes 656 and rises where xc becomes 752, i.e. 96 ticks = 384 clks low.
  - video_on falls when xc becomes 640.
  - xc wraps 799->0 with yc incrementing on the same edge.
- Frame timing:
  - vsync is low exactly for yc=490..491, i.e. 1600 ticks.
  - yc wraps 524->0 coincident with the frame_end pulse.
  - frame_end pulses are spaced 1,680,000 clks apart.
- vblank_start: a single one-clk pulse coincident with pixel_tick at xc=639, yc=479; never asserted elsewhere over two full frames. Count one vblank_start and one frame_end per frame.
- Mid-frame reset: assert reset asynchronously (between clk edges) at xc=700, yc=300 -> outputs take reset values immediately. After release, counting restarts from (0,0) with no stray strobe.
- Parameter override: CLK_DIV=2 with a reduced raster (H 8/2/2/2, V 4/1/1/1) -> pixel_tick every 2 clks; hsync active at xc=10..11; vsync active at yc=5; frame_end every 14*7*2=196 clks.
